// File: rtl/tx_sample_packer.sv
// tx_sample_packer: sign-magnitude to two's-complement packer with FIFO and fixed-rate output strobe
module tx_sample_packer #(
    parameter int DEPTH    = 4,
    parameter int RATE_DIV = 8
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     tx_enable,
    input  logic                     in_real_sign,
    input  logic [14:0]              in_real_mag,
    input  logic                     in_imag_sign,
    input  logic [14:0]              in_imag_mag,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     clear_underrun,
    output logic [31:0]              data,
    output logic                     data_ready,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(RATE_DIV);

    // Negative zero folds to 0, so 16'h8000 can never appear
    function automatic logic [15:0] to_twos(input logic sign, input logic [14:0] mag);
        return (sign && mag != 15'd0) ? ~{1'b0, mag} + 16'd1 : {1'b0, mag};
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          push, strobe, pop, empty;

    assign empty    = fifo_level == LW'(0);
    assign in_ready = fifo_level != LW'(DEPTH);
    assign push     = in_valid && in_ready;
    assign strobe   = tx_enable && cnt == CW'(RATE_DIV - 1);
    assign pop      = strobe && !empty;

    always_ff @(posedge sys_clk)
        if (push)
            mem[wr_ptr] <= {to_twos(in_real_sign, in_real_mag), to_twos(in_imag_sign, in_imag_mag)};

    always_ff @(posedge sys_clk or posedge reset)
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cnt        <= '0;
            data       <= '0;
            data_ready <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            cnt        <= (!tx_enable || strobe) ? '0 : cnt + CW'(1);
            data_ready <= strobe;
            if (strobe)
                data <= empty ? 32'h0 : mem[rd_ptr];
            // A new underrun event outranks a simultaneous clear
            if (strobe && empty)
                underrun <= 1'b1;
            else if (clear_underrun)
                underrun <= 1'b0;
        end
endmodule
